// File: rtl/alu.sv
// Single-cycle RV32I integer ALU: decodes the issued op, computes the value and
// the control-transfer outcome, and broadcasts a registered result one cycle later.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        alu_en,
  input  logic [6:0]  alu_opcode,
  input  logic [2:0]  alu_func3,
  input  logic        alu_func1,
  input  logic [31:0] alu_val1,
  input  logic [31:0] alu_val2,
  input  logic [31:0] alu_imm,
  input  logic [31:0] alu_pc,
  input  logic [3:0]  alu_rob_pos,
  output logic        result,
  output logic [3:0]  result_rob_pos,
  output logic [31:0] result_val,
  output logic        result_jump,
  output logic [31:0] result_pc
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [31:0] arith;
  logic [31:0] pc_plus4;
  logic [31:0] pc_imm;
  logic [31:0] jalr_tgt;
  logic        taken;
  logic [31:0] nxt_val;
  logic        nxt_jump;
  logic [31:0] nxt_pc;

  assign op2      = (alu_opcode == OPC_OP) ? alu_val2 : alu_imm;
  assign shamt    = op2[4:0];
  assign pc_plus4 = alu_pc + 32'd4;
  assign pc_imm   = alu_pc + alu_imm;
  assign jalr_tgt = (alu_val1 + alu_imm) & 32'hFFFF_FFFE;

  // func1 selects SUB only for register ops; for immediates bit 30 is part of imm
  always_comb begin
    arith = 32'd0;
    case (alu_func3)
      3'b000:  arith = (alu_opcode == OPC_OP && alu_func1) ? alu_val1 - op2 : alu_val1 + op2;
      3'b001:  arith = alu_val1 << shamt;
      3'b010:  arith = {31'd0, $signed(alu_val1) < $signed(op2)};
      3'b011:  arith = {31'd0, alu_val1 < op2};
      3'b100:  arith = alu_val1 ^ op2;
      3'b101:  arith = alu_func1 ? 32'($signed(alu_val1) >>> shamt) : alu_val1 >> shamt;
      3'b110:  arith = alu_val1 | op2;
      default: arith = alu_val1 & op2;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (alu_func3)
      3'b000:  taken = alu_val1 == alu_val2;
      3'b001:  taken = alu_val1 != alu_val2;
      3'b100:  taken = $signed(alu_val1) <  $signed(alu_val2);
      3'b101:  taken = $signed(alu_val1) >= $signed(alu_val2);
      3'b110:  taken = alu_val1 <  alu_val2;
      3'b111:  taken = alu_val1 >= alu_val2;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    nxt_val  = 32'd0;
    nxt_jump = 1'b0;
    nxt_pc   = pc_plus4;
    case (alu_opcode)
      OPC_OP, OPC_OP_IMM: nxt_val = arith;
      OPC_LUI:            nxt_val = alu_imm;
      OPC_AUIPC:          nxt_val = pc_imm;
      OPC_JAL: begin
        nxt_val  = pc_plus4;
        nxt_jump = 1'b1;
        nxt_pc   = pc_imm;
      end
      OPC_JALR: begin
        nxt_val  = pc_plus4;
        nxt_jump = 1'b1;
        nxt_pc   = jalr_tgt;
      end
      OPC_BRANCH: begin
        nxt_jump = taken;
        nxt_pc   = taken ? pc_imm : pc_plus4;
      end
      default: ;
    endcase
  end

  // rollback kills the broadcast even while stalled; payload registers just hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result         <= 1'b0;
      result_rob_pos <= 4'd0;
      result_val     <= 32'd0;
      result_jump    <= 1'b0;
      result_pc      <= 32'd0;
    end else if (rollback) begin
      result <= 1'b0;
    end else if (rdy) begin
      result <= alu_en;
      if (alu_en) begin
        result_rob_pos <= alu_rob_pos;
        result_val     <= nxt_val;
        result_jump    <= nxt_jump;
        result_pc      <= nxt_pc;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes hand-computed responses, a monitor
// pops and compares whenever a fresh broadcast appears.
module tb_alu;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] AUI  = 7'b0010111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR   = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_func3;
  logic        alu_func1;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;
  logic        result;
  logic [3:0]  result_rob_pos;
  logic [31:0] result_val;
  logic        result_jump;
  logic [31:0] result_pc;

  alu dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
    .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func1(alu_func1),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_rob_pos(alu_rob_pos), .result(result), .result_rob_pos(result_rob_pos),
    .result_val(result_val), .result_jump(result_jump), .result_pc(result_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] val;
    logic        jump;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  bit   have_held = 0;
  bit   e_rdy = 0, e_rb = 0;
  bit   fin = 0;
  int   n_cmp = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  always @(posedge clk) begin
    e_rdy = rdy;
    e_rb  = rollback;
  end

  // monitor: reset, rollback, fresh broadcast, or held output during a stall
  always @(negedge clk or negedge rst) begin
    exp_t e;
    #1;
    if (!rst) begin
      exp_q.delete();
      have_held = 0;
      chk("rst_result", {31'd0, result}, 32'd0);
      chk("rst_rob",    {28'd0, result_rob_pos}, 32'd0);
      chk("rst_val",    result_val, 32'd0);
      chk("rst_jump",   {31'd0, result_jump}, 32'd0);
      chk("rst_pc",     result_pc, 32'd0);
    end else if (fin) begin
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end else if (e_rb) begin
      have_held = 0;
      chk("rollback_result", {31'd0, result}, 32'd0);
    end else if (e_rdy) begin
      if (result) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {31'd0, result}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rob",  {28'd0, result_rob_pos}, {28'd0, e.rob});
          chk("val",  result_val, e.val);
          chk("jump", {31'd0, result_jump}, {31'd0, e.jump});
          chk("pc",   result_pc, e.pc);
          held = e;
          have_held = 1;
        end
      end else begin
        have_held = 0;
      end
    end else if (have_held) begin
      chk("stall_result", {31'd0, result}, 32'd1);
      chk("stall_rob",    {28'd0, result_rob_pos}, {28'd0, held.rob});
      chk("stall_val",    result_val, held.val);
    end
  end

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f1,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [3:0] rob);
    alu_opcode = op; alu_func3 = f3; alu_func1 = f1;
    alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc; alu_rob_pos = rob;
  endtask

  task automatic op_issue(input logic [6:0] op, input logic [2:0] f3, input logic f1,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [3:0] rob,
                          input logic [31:0] ev, input logic ej, input logic [31:0] epc);
    exp_t e;
    set_in(op, f3, f1, v1, v2, imm, pc, rob);
    alu_en = 1'b1;
    if (rdy && !rollback) begin
      e.rob = rob; e.val = ev; e.jump = ej; e.pc = epc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    alu_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0;
    set_in(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    #22 rst = 1'b1;
    @(posedge clk); #1;

    // back-to-back issue across the opcode space
    op_issue(OP,  3'd0, 1'b1, 32'd5,          32'd7,    32'd0,      32'h0,    4'd3,  32'hFFFF_FFFE, 1'b0, 32'h4);
    op_issue(OPI, 3'd5, 1'b1, 32'h8000_0000,  32'd0,    32'h404,    32'h10,   4'd1,  32'hF800_0000, 1'b0, 32'h14);
    op_issue(OPI, 3'd5, 1'b0, 32'h8000_0000,  32'd0,    32'h404,    32'h20,   4'd2,  32'h0800_0000, 1'b0, 32'h24);
    op_issue(BR,  3'd4, 1'b0, 32'hFFFF_FFFF,  32'd1,    32'h20,     32'h100,  4'd4,  32'd0,         1'b1, 32'h120);
    op_issue(BR,  3'd6, 1'b0, 32'hFFFF_FFFF,  32'd1,    32'h20,     32'h100,  4'd5,  32'd0,         1'b0, 32'h104);
    op_issue(JALR,3'd0, 1'b0, 32'h1001,       32'd0,    32'd2,      32'h200,  4'd6,  32'h204,       1'b1, 32'h1002);
    op_issue(OPI, 3'd0, 1'b1, 32'd10,         32'd99,   32'd3,      32'h30,   4'd7,  32'd13,        1'b0, 32'h34);
    op_issue(OP,  3'd1, 1'b0, 32'd1,          32'd33,   32'd0,      32'h40,   4'd8,  32'd2,         1'b0, 32'h44);
    op_issue(OP,  3'd2, 1'b0, 32'hFFFF_FFFF,  32'd0,    32'd0,      32'h50,   4'd9,  32'd1,         1'b0, 32'h54);
    op_issue(OP,  3'd3, 1'b0, 32'hFFFF_FFFF,  32'd0,    32'd0,      32'h50,   4'd10, 32'd0,         1'b0, 32'h54);
    op_issue(OP,  3'd0, 1'b0, 32'hFFFF_FFFF,  32'd1,    32'd0,      32'h50,   4'd11, 32'd0,         1'b0, 32'h54);
    op_issue(LUI, 3'd0, 1'b0, 32'd0,          32'd0,    32'h1234_5000, 32'h60, 4'd12, 32'h1234_5000, 1'b0, 32'h64);
    op_issue(AUI, 3'd0, 1'b0, 32'd0,          32'd0,    32'h2000,   32'h1000, 4'd13, 32'h3000,      1'b0, 32'h1004);
    op_issue(JAL, 3'd0, 1'b0, 32'd0,          32'd0,    32'hFFFF_FFF0, 32'h40, 4'd14, 32'h44,        1'b1, 32'h30);
    op_issue(BR,  3'd0, 1'b0, 32'd7,          32'd7,    32'd8,      32'h80,   4'd15, 32'd0,         1'b1, 32'h88);
    op_issue(BR,  3'd1, 1'b0, 32'd7,          32'd7,    32'd8,      32'h80,   4'd0,  32'd0,         1'b0, 32'h84);
    op_issue(BR,  3'd7, 1'b0, 32'hFFFF_FFFF,  32'd1,    32'd8,      32'h80,   4'd1,  32'd0,         1'b1, 32'h88);
    op_issue(BR,  3'd5, 1'b0, 32'hFFFF_FFFF,  32'd1,    32'd8,      32'h80,   4'd2,  32'd0,         1'b0, 32'h84);
    op_issue(7'h7F,3'd0,1'b0, 32'd5,          32'd5,    32'd4,      32'h90,   4'd3,  32'd0,         1'b0, 32'h94);
    op_issue(OP,  3'd4, 1'b0, 32'hF0F0,       32'hFF00, 32'd0,      32'h0,    4'd4,  32'h0FF0,      1'b0, 32'h4);
    op_issue(OP,  3'd6, 1'b0, 32'hF0F0,       32'hFF00, 32'd0,      32'h0,    4'd5,  32'hFFF0,      1'b0, 32'h4);
    op_issue(OP,  3'd7, 1'b0, 32'hF0F0,       32'hFF00, 32'd0,      32'h0,    4'd6,  32'hF000,      1'b0, 32'h4);
    op_issue(OP,  3'd5, 1'b1, 32'h8000_0000,  32'h24,   32'd0,      32'h0,    4'd7,  32'hF800_0000, 1'b0, 32'h4);
    idle(2);

    // stall: first result held, alu_en asserted during stall must be ignored
    op_issue(OP,  3'd0, 1'b0, 32'd1,          32'd2,    32'd0,      32'h8,    4'd9,  32'd3,         1'b0, 32'hC);
    rdy = 1'b0;
    set_in(OP, 3'd0, 1'b0, 32'd100, 32'd1, 32'd0, 32'h0, 4'd1);
    alu_en = 1'b1;
    idle(2);
    rdy = 1'b1;
    op_issue(OP,  3'd0, 1'b0, 32'd100,        32'd1,    32'd0,      32'h0,    4'd10, 32'd101,       1'b0, 32'h4);
    op_issue(OP,  3'd0, 1'b1, 32'd100,        32'd1,    32'd0,      32'h0,    4'd11, 32'd99,        1'b0, 32'h4);
    idle(2);

    // rollback on the same edge as alu_en: nothing broadcast
    rollback = 1'b1;
    op_issue(OP,  3'd0, 1'b0, 32'd1,          32'd1,    32'd0,      32'h0,    4'd12, 32'd2,         1'b0, 32'h4);
    rollback = 1'b0;
    idle(1);

    // rollback while stalled still clears a live broadcast
    op_issue(OP,  3'd0, 1'b0, 32'd4,          32'd4,    32'd0,      32'h0,    4'd13, 32'd8,         1'b0, 32'h4);
    rdy = 1'b0; rollback = 1'b1;
    idle(1);
    rdy = 1'b1; rollback = 1'b0;
    idle(2);

    // reset pulse between edges while a broadcast is live
    op_issue(OP,  3'd0, 1'b0, 32'd6,          32'd6,    32'd0,      32'h0,    4'd14, 32'd12,        1'b0, 32'h4);
    rst = 1'b0;
    #2 rst = 1'b1;
    idle(2);
    op_issue(OP,  3'd0, 1'b0, 32'd9,          32'd9,    32'd0,      32'h70,   4'd15, 32'd18,        1'b0, 32'h74);
    idle(3);
    fin = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary within time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge except reset.
REQ-002 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 rdy  in  1  global enable; 0 freezes all state.
REQ-004 rollback  in  1  synchronous flush from ROB on mispredict.
REQ-005 alu_en  in  1  issue valid from reservation station, one-cycle pulse per instruction.
REQ-006 alu_opcode  in  7  RV32I opcode.
REQ-007 alu_func3  in  3  funct3.
REQ-008 alu_func1  in  1  instruction bit 30.
REQ-009 alu_val1 / alu_val2  in  32 each  rs1 / rs2 operand values.
REQ-010 alu_imm  in  32  sign-extended immediate (LUI/AUIPC: already shifted).
REQ-011 alu_pc  in  32  instruction address.
REQ-012 alu_rob_pos  in  4  destination ROB slot.
REQ-013 result  out  1  broadcast valid, one-cycle pulse.
REQ-014 result_rob_pos  out  4  ROB slot of broadcast.
REQ-015 result_val  out  32  value written to rd.
REQ-016 result_jump  out  1  1 = control transfer taken.
REQ-017 result_pc  out  32  resolved next PC for control instructions.

Function
REQ-018 Latency SHALL be exactly 1 cycle: alu_en sampled at edge N with rdy=1 -> result=1 during cycle N+1 with registered outputs.
REQ-019 result SHALL deassert the cycle after a broadcast unless a new alu_en was sampled; back-to-back issue every cycle SHALL give back-to-back pulses with no bubble.
REQ-020 result_rob_pos SHALL equal the captured alu_rob_pos.
REQ-021 OP (0110011): func3 000 ADD/SUB (func1=1 SUB), 001 SLL, 010 SLT signed, 011 SLTU, 100 XOR, 101 SRL/SRA (func1=1 SRA), 110 OR, 111 AND; operand2=val2.
REQ-022 OP-IMM (0010011): same table with operand2=imm; func1 SHALL be ignored except for func3=101.
REQ-023 Shift amount SHALL be operand2[4:0]; all arithmetic modulo 2^32; SLT/SLTU produce 0 or 1.
REQ-024 LUI (0110111): result_val=imm; AUIPC (0010111): result_val=pc+imm.
REQ-025 JAL (1101111): result_val=pc+4, result_jump=1, result_pc=pc+imm.
REQ-026 JALR (1100111): result_val=pc+4, result_jump=1, result_pc=(val1+imm) with bit0 cleared.
REQ-027 BRANCH (1100011): func3 000 EQ, 001 NE, 100 LT, 101 GE (signed), 110 LTU, 111 GEU; taken -> result_jump=1, result_pc=pc+imm; not taken -> result_jump=0, result_pc=pc+4; result_val=0.
REQ-028 Non-control opcodes SHALL drive result_jump=0, result_pc=pc+4.
REQ-029 Unknown opcode SHALL still broadcast, result_val=0, result_jump=0.
REQ-030 rdy=0 SHALL hold every output register unchanged and ignore alu_en.
REQ-031 rollback=1 at an edge (rdy any) SHALL clear result to 0 next cycle and discard any alu_en sampled that edge; rollback has priority over alu_en.

Reset
REQ-032 rst=0 SHALL immediately force result=0, result_jump=0, result_rob_pos=0, result_val=0, result_pc=0, independent of clk and rdy.
REQ-033 Reset asserted mid-operation SHALL drop the pending broadcast; first broadcast after release requires a fresh alu_en.

Verification
REQ-034 OP SUB val1=5, val2=7, rob_pos=3 -> next cycle result=1, rob_pos=3, val=0xFFFFFFFE, jump=0.
REQ-035 OP-IMM SRAI val1=0x80000000, imm=0x404 (func1=1, func3=101) -> val=0xF8000000; same with func1=0 -> 0x08000000.
REQ-036 BLT val1=0xFFFFFFFF, val2=1, pc=0x100, imm=0x20 -> jump=1, pc=0x120; BLTU same operands -> jump=0, pc=0x104.
REQ-037 JALR pc=0x200, val1=0x1001, imm=2 -> val=0x204, jump=1, result_pc=0x1002.
REQ-038 Three consecutive alu_en with rdy dropped for 2 cycles after the first -> first result held through stall, remaining two broadcast on consecutive cycles after rdy returns.
REQ-039 alu_en and rollback same edge -> no broadcast; rst=0 pulse between edges while result=1 -> result=0 immediately.
